keypad_entry: RTL and testbench

Parametrised successor to the fixed two-digit keyboard controller. Scans a 4x3 matrix keypad and debounces each press and release with a four-state FSM. Assembles `DIGITS` BCD digits into a number, hands it to game memory over a valid/ready handshake, and issues the game-start pulse. Sits between the keypad pins and `game_mem` / `game_logic` in `top`.

---
 rtl/keypad_entry.sv | 205 ++++++++++++++++++++
 tb/tb_keypad_entry.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - 4x3 keypad scanner, debouncer and BCD number assembler
// Optional build macro: KEYPAD_BACKSPACE_EN (A deletes newest digit instead of clearing entry).
module keypad_entry #(
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [2:0]            keyboard_cols,
    output logic [3:0]            keyboard_rows,
    output logic [4*DIGITS-1:0]   num_data,
    output logic                  num_valid,
    input  logic                  num_ready,
    output logic                  start_game,
    output logic                  locked,
    output logic [4*DIGITS-1:0]   entry_digits,
    output logic [2:0]            entry_count
);

    localparam int W  = 4 * DIGITS;
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;

    localparam logic [3:0] KEY_A = 4'd10;
    localparam logic [3:0] KEY_B = 4'd11;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_PRESS_DB,
        ST_HELD,
        ST_RELEASE_DB
    } state_t;

    state_t          state_q;
    logic [3:0]      rows_q;
    logic [2:0]      col_q;
    logic [SW-1:0]   slot_q;
    logic [DW-1:0]   db_q;

    logic [W-1:0]    num_data_q;
    logic            num_valid_q;
    logic            start_game_q;
    logic            locked_q;
    logic [W-1:0]    entry_q;
    logic [2:0]      count_q;

    logic            cols_onehot;
    logic            slot_last;
    logic            db_last;
    logic            accept;
    logic [3:0]      key_code;
    logic [W-1:0]    shifted_d;
    logic [2:0]      count_inc_d;

    assign cols_onehot = (keyboard_cols == 3'b100) || (keyboard_cols == 3'b010) ||
                         (keyboard_cols == 3'b001);
    assign slot_last   = (slot_q == SW'(SCAN_DIV - 1));
    assign db_last     = (db_q == DW'(DEBOUNCE - 1));
    assign accept      = (state_q == ST_PRESS_DB) && (keyboard_cols == col_q) && db_last;
    assign shifted_d   = (entry_q << 4) | W'(key_code);
    assign count_inc_d = count_q + 3'd1;

    // Key code from the frozen row drive and the latched column: 0-9 digits, 10 = A, 11 = B.
    always_comb begin
        key_code = 4'd0;
        case ({rows_q, col_q})
            7'b1000_100: key_code = 4'd1;
            7'b1000_010: key_code = 4'd2;
            7'b1000_001: key_code = 4'd3;
            7'b0100_100: key_code = 4'd4;
            7'b0100_010: key_code = 4'd5;
            7'b0100_001: key_code = 4'd6;
            7'b0010_100: key_code = 4'd7;
            7'b0010_010: key_code = 4'd8;
            7'b0010_001: key_code = 4'd9;
            7'b0001_100: key_code = KEY_A;
            7'b0001_010: key_code = 4'd0;
            7'b0001_001: key_code = KEY_B;
            default:     key_code = 4'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_SCAN;
            rows_q  <= 4'b1000;
            col_q   <= 3'b000;
            slot_q  <= '0;
            db_q    <= '0;
        end else begin
            case (state_q)
                ST_SCAN: begin
                    if (slot_last) begin
                        slot_q <= '0;
                        if (cols_onehot) begin
                            col_q   <= keyboard_cols;
                            db_q    <= '0;
                            state_q <= ST_PRESS_DB;
                        end else begin
                            rows_q <= {rows_q[0], rows_q[3:1]};
                        end
                    end else begin
                        slot_q <= slot_q + 1'b1;
                    end
                end
                ST_PRESS_DB: begin
                    // A bounce rescans the same row from the start of its slot.
                    if (keyboard_cols != col_q) begin
                        state_q <= ST_SCAN;
                        slot_q  <= '0;
                        db_q    <= '0;
                    end else if (db_last) begin
                        state_q <= ST_HELD;
                        db_q    <= '0;
                    end else begin
                        db_q <= db_q + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (keyboard_cols == 3'b000) begin
                        state_q <= ST_RELEASE_DB;
                        db_q    <= '0;
                    end
                end
                ST_RELEASE_DB: begin
                    if (keyboard_cols != 3'b000) begin
                        state_q <= ST_HELD;
                        db_q    <= '0;
                    end else if (db_last) begin
                        state_q <= ST_SCAN;
                        rows_q  <= {rows_q[0], rows_q[3:1]};
                        slot_q  <= '0;
                        db_q    <= '0;
                    end else begin
                        db_q <= db_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_SCAN;
                    rows_q  <= 4'b1000;
                    slot_q  <= '0;
                    db_q    <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            num_data_q   <= '0;
            num_valid_q  <= 1'b0;
            start_game_q <= 1'b0;
            locked_q     <= 1'b0;
            entry_q      <= '0;
            count_q      <= 3'd0;
        end else begin
            start_game_q <= 1'b0;
            if (num_valid_q && num_ready) begin
                num_valid_q <= 1'b0;
            end
            if (accept && !locked_q) begin
                if (key_code <= 4'd9) begin
                    if (!num_valid_q && (count_q != 3'(DIGITS))) begin
                        if (count_inc_d == 3'(DIGITS)) begin
                            num_data_q  <= shifted_d;
                            num_valid_q <= 1'b1;
                            entry_q     <= '0;
                            count_q     <= 3'd0;
                        end else begin
                            entry_q <= shifted_d;
                            count_q <= count_inc_d;
                        end
                    end
                end else if (key_code == KEY_A) begin
                    if (!num_valid_q) begin
`ifdef KEYPAD_BACKSPACE_EN
                        if (count_q != 3'd0) begin
                            entry_q <= entry_q >> 4;
                            count_q <= count_q - 3'd1;
                        end
`else
                        entry_q <= '0;
                        count_q <= 3'd0;
`endif
                    end
                end else if (key_code == KEY_B) begin
                    if ((count_q == 3'd0) && !num_valid_q) begin
                        start_game_q <= 1'b1;
                        locked_q     <= 1'b1;
                    end
                end
            end
        end
    end

    assign keyboard_rows = rows_q;
    assign num_data      = num_data_q;
    assign num_valid     = num_valid_q;
    assign start_game    = start_game_q;
    assign locked        = locked_q;
    assign entry_digits  = entry_q;
    assign entry_count   = count_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - scoreboard bench for keypad_entry with a keypad matrix model
module tb_keypad_entry;

    localparam int DIGITS   = 2;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 16;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] cols;
    logic [3:0] rows;
    logic [7:0] num_data;
    logic       num_valid;
    logic       num_ready = 1'b0;
    logic       start_game;
    logic       locked;
    logic [7:0] entry_digits;
    logic [2:0] entry_count;

    always #5 clk = ~clk;

    keypad_entry #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .keyboard_cols (cols),
        .keyboard_rows (rows),
        .num_data      (num_data),
        .num_valid     (num_valid),
        .num_ready     (num_ready),
        .start_game    (start_game),
        .locked        (locked),
        .entry_digits  (entry_digits),
        .entry_count   (entry_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Physical keypad: a pressed key connects its row line to its column line.
    logic key_on = 1'b0, force_zero = 1'b0, force_dual = 1'b0;
    int   key_r = 0, key_c = 0;

    always_comb begin
        cols = 3'b000;
        if (force_dual)
            cols = 3'b110;
        else if (key_on && !force_zero && rows[3-key_r])
            cols = 3'b100 >> key_c;
    end

    // Reference model: partial entry as a digit list, one pending number, a lock flag.
    typedef struct { int kind; logic [31:0] data; } ev_t;
    ev_t exp_q[$];
    int  m_entry[$];
    bit  m_pending = 0;
    bit  m_locked = 0;

    function automatic logic [31:0] m_digits();
        logic [31:0] v = 0;
        foreach (m_entry[i]) v = v * 16 + m_entry[i];
        return v;
    endfunction

    task automatic model_key(int k);
        ev_t e;
        if (m_locked) return;
        if (k <= 9) begin
            if (!m_pending && m_entry.size() < DIGITS) begin
                m_entry.push_back(k);
                if (m_entry.size() == DIGITS) begin
                    e.kind = 0;
                    e.data = m_digits();
                    exp_q.push_back(e);
                    m_pending = 1;
                    m_entry.delete();
                end
            end
        end else if (k == 10) begin
            if (!m_pending) begin
`ifdef KEYPAD_BACKSPACE_EN
                if (m_entry.size() > 0) void'(m_entry.pop_back());
`else
                m_entry.delete();
`endif
            end
        end else begin
            if (m_entry.size() == 0 && !m_pending) begin
                e.kind = 1;
                e.data = 1;
                exp_q.push_back(e);
                m_locked = 1;
            end
        end
    endtask

    task automatic sb_pop(int kind, logic [31:0] data, string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected event actual=%0h required=none", name, data);
        end else begin
            e = exp_q.pop_front();
            check({name, "_kind"}, kind, e.kind);
            check(name, data, e.data);
        end
    endtask

    logic       prev_valid = 1'b0, prev_start = 1'b0;
    logic [7:0] held_data = 8'h00;

    always @(negedge clk) begin
        if (rstn) begin
            if (num_valid && !prev_valid) begin
                sb_pop(0, num_data, "num_data");
                held_data = num_data;
            end else if (num_valid && prev_valid) begin
                check("num_data_stable", num_data, held_data);
            end
            if (start_game) begin
                check("start_one_cycle", prev_start, 0);
                if (!prev_start) sb_pop(1, 1, "start_game");
            end
        end
        prev_valid = num_valid;
        prev_start = start_game;
    end

    task automatic set_key(int k);
        if (k >= 1 && k <= 9) begin
            key_r = (k - 1) / 3;
            key_c = (k - 1) % 3;
        end else begin
            key_r = 3;
            key_c = (k == 0) ? 1 : (k == 10) ? 0 : 2;
        end
    endtask

    task automatic wait_row(string name);
        int n = 0;
        while (!rows[3-key_r] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_row_timeout"}, (n >= 100), 0);
    endtask

    task automatic press(int k, bit bounce = 0);
        model_key(k);
        set_key(k);
        @(negedge clk);
        key_on = 1'b1;
        if (bounce) begin
            wait_row("bounce");
            repeat (SCAN_DIV + 6) @(negedge clk);
            force_zero = 1'b1;
            @(negedge clk);
            force_zero = 1'b0;
            repeat (70) @(negedge clk);
        end else begin
            repeat (80) @(negedge clk);
        end
        key_on = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    task automatic check_entry(string tag);
        check({tag, "_count"}, entry_count, m_entry.size());
        check({tag, "_digits"}, entry_digits, m_digits());
        check({tag, "_valid"}, num_valid, m_pending);
    endtask

    task automatic pulse_ready();
        @(negedge clk);
        num_ready = 1'b1;
        @(negedge clk);
        num_ready = 1'b0;
        m_pending = 0;
        check("valid_after_ready", num_valid, 0);
    endtask

    task automatic check_reset(string tag);
        check({tag, "_rows"}, rows, 4'b1000);
        check({tag, "_valid"}, num_valid, 0);
        check({tag, "_data"}, num_data, 0);
        check({tag, "_start"}, start_game, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_digits"}, entry_digits, 0);
        check({tag, "_count"}, entry_count, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seen;
        int k;

        repeat (3) @(posedge clk);
        #1 check_reset("reset");

        // Key 0 sits in the fourth scan slot: detected on edge 4*SCAN_DIV, accepted DEBOUNCE later.
        @(negedge clk);
        rstn = 1'b1;
        model_key(0);
        set_key(0);
        key_on = 1'b1;
        repeat (4 * SCAN_DIV + DEBOUNCE - 1) @(posedge clk);
        #1 check("latency_early_count", entry_count, 0);
        @(posedge clk);
        #1 check("latency_accept_count", entry_count, 1);
        repeat (30) @(negedge clk);
        key_on = 1'b0;
        repeat (40) @(negedge clk);
        check_entry("key0");

        press(2);
        check_entry("num02");
        check("num02_data", num_data, 8'h02);
        pulse_ready();

        press(1);
        press(5);
        press(7);
        check_entry("drop7");
        check("pending15_data", num_data, 8'h15);
        pulse_ready();

        press(3, 1);
        check_entry("bounce3");
        check("bounce3_nibble", entry_digits[3:0], 4'd3);

        press(10);
        check_entry("clear_a");
        press(9);
        press(10);
        check_entry("nine_a");

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) pulse_ready();
            k = $urandom_range(0, 11);
            if (k == 11 && m_entry.size() == 0 && !m_pending) k = 10;
            press(k);
            check_entry("random");
        end

        pulse_ready();
        press(10);
        check_entry("pre_lock_clear");
        press(1);
        press(11);
        check_entry("b_ignored");
        check("b_ignored_locked", locked, 0);
        press(10);
        press(11);
        check("locked_set", locked, 1);
        press(4);
        press(6);
        check_entry("locked_entry");

        @(negedge clk);
        force_dual = 1'b1;
        seen = 4'b0000;
        repeat (40) begin
            @(negedge clk);
            seen |= rows;
        end
        force_dual = 1'b0;
        check("dual_rows_rotate", seen, 4'b1111);

        set_key(1);
        key_on = 1'b1;
        @(negedge clk);
        wait_row("reset_mid");
        repeat (SCAN_DIV + 3) @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1 check_reset("reset_mid");
        key_on = 1'b0;
        repeat (3) @(negedge clk);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
